digit_serial_add_ctrl: RTL and testbench

- Sequencer that adds two WIDTH-bit operands over multiple cycles.
- It reuses one 2-bit ripple-carry digit adder, which processes 2 bits per cycle, LSB digit first.
- The inter-digit carry is held in a register between cycles.
- Sits between a producer and a consumer with valid/ready handshakes. It replaces a wide combinational adder when area matters more than latency.

---
 rtl/dsa_pkg.sv | 19 +
 rtl/dsa_digit_adder.sv | 21 ++
 rtl/digit_serial_add_ctrl.sv | 151 +++++++++++++++
 tb/tb_digit_serial_add_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsa_pkg.sv
// Shared types and helpers for the digit-serial adder controller.
package dsa_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } dsa_state_e;

    localparam int unsigned DIGIT_W = 2;

    // Digit counter width: clog2(number of digits), never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned width);
        int unsigned ndig;
        ndig = width / DIGIT_W;
        return (ndig <= 1) ? 1 : $clog2(ndig);
    endfunction

endpackage

// File: rtl/dsa_digit_adder.sv
// Combinational 2-bit ripple-carry digit adder made of two full-adder cells.
module dsa_digit_adder
    import dsa_pkg::*;
(
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               ci,
    output logic [DIGIT_W-1:0] s,
    output logic               co
);

    logic w_c1;

    always_comb begin
        s[0] = a[0] ^ b[0] ^ ci;
        w_c1 = (a[0] & b[0]) | (ci & (a[0] ^ b[0]));
        s[1] = a[1] ^ b[1] ^ w_c1;
        co   = (a[1] & b[1]) | (w_c1 & (a[1] ^ b[1]));
    end

endmodule

// File: rtl/digit_serial_add_ctrl.sv
// Digit-serial WIDTH-bit adder sequencer, 2 bits per cycle LSB first, valid/ready on both sides.
// Optional subtract mode and signed-overflow flag enabled by defining DSA_SUBTRACT_EN.
module digit_serial_add_ctrl
    import dsa_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef DSA_SUBTRACT_EN
    input  logic             sub,
    output logic             ovf,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int unsigned NDIG  = WIDTH / DIGIT_W;
    localparam int unsigned CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NDIG - 1);

    dsa_state_e         r_state;
    dsa_state_e         w_state_nxt;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-1:0]   r_sum_sh;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_accept;
    logic               w_last;
    logic [DIGIT_W-1:0] w_dig_s;
    logic               w_dig_c;
    logic [WIDTH-1:0]   w_sum_nxt;
    logic [WIDTH-1:0]   w_b_in;
    logic               w_c_in;

    assign w_accept = in_valid && (r_state == IDLE);
    assign w_last   = (r_state == RUN) && (r_cnt == CNT_LAST);

`ifdef DSA_SUBTRACT_EN
    // Two's-complement subtract: invert b and inject a carry of one.
    assign w_b_in = sub ? ~b : b;
    assign w_c_in = sub ? 1'b1 : cin;
`else
    assign w_b_in = b;
    assign w_c_in = cin;
`endif

    dsa_digit_adder u_digit_adder (
        .a  (r_a_sh[DIGIT_W-1:0]),
        .b  (r_b_sh[DIGIT_W-1:0]),
        .ci (r_carry),
        .s  (w_dig_s),
        .co (w_dig_c)
    );

    generate
        if (WIDTH == DIGIT_W) begin : g_narrow
            assign w_sum_nxt = w_dig_s;
        end else begin : g_wide
            assign w_sum_nxt = {w_dig_s, r_sum_sh[WIDTH-1:DIGIT_W]};
        end
    endgenerate

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (in_valid)  w_state_nxt = RUN;
            RUN:     if (w_last)    w_state_nxt = DONE;
            DONE:    if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from registered state only
    always_comb begin
        in_ready  = (r_state == IDLE);
        busy      = (r_state == RUN);
        out_valid = (r_state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_sum_sh <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
        end else if (w_accept) begin
            r_a_sh   <= a;
            r_b_sh   <= w_b_in;
            r_sum_sh <= '0;
            r_carry  <= w_c_in;
            r_cnt    <= '0;
        end else if (r_state == RUN) begin
            r_a_sh   <= r_a_sh >> DIGIT_W;
            r_b_sh   <= r_b_sh >> DIGIT_W;
            r_sum_sh <= w_sum_nxt;
            r_carry  <= w_dig_c;
            // Hold at the last digit so the counter never wraps.
            if (!w_last) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign sum  = r_sum_sh;
    assign cout = r_carry;

`ifdef DSA_SUBTRACT_EN
    logic r_a_msb;
    logic r_b_msb;
    logic r_ovf;

    // Signed overflow: operand signs agree but the result sign differs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_a_msb <= a[WIDTH-1];
            r_b_msb <= w_b_in[WIDTH-1];
        end else if (w_last) begin
            r_ovf <= (r_a_msb == r_b_msb) && (w_sum_nxt[WIDTH-1] != r_a_msb);
        end
    end

    assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_digit_serial_add_ctrl.sv
// Self-checking bench: vector table, multi-cycle corner cases, random ops vs arithmetic model.
module tb_digit_serial_add_ctrl;

    localparam int W    = 8;
    localparam int NDIG = W / 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, out_valid, out_ready, cin, cout, busy;
    logic [W-1:0] a, b, sum;
    logic         in_valid_2, in_ready_2, out_valid_2, out_ready_2, cin_2, cout_2, busy_2;
    logic [1:0]   a_2, b_2, sum_2;
    logic         sub, ovf, sub_2, ovf_2;

    always #5 clk = ~clk;

    digit_serial_add_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef DSA_SUBTRACT_EN
        .sub       (sub),
        .ovf       (ovf),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    digit_serial_add_ctrl #(.WIDTH(2)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid_2),
        .in_ready  (in_ready_2),
        .a         (a_2),
        .b         (b_2),
        .cin       (cin_2),
`ifdef DSA_SUBTRACT_EN
        .sub       (sub_2),
        .ovf       (ovf_2),
`endif
        .out_valid (out_valid_2),
        .out_ready (out_ready_2),
        .sum       (sum_2),
        .cout      (cout_2),
        .busy      (busy_2)
    );

`ifndef DSA_SUBTRACT_EN
    assign ovf   = 1'b0;
    assign ovf_2 = 1'b0;
`endif

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Throughput monitor: successive acceptances at least NDIG+2 cycles apart.
    int cyc = 0;
    int prev_acc = 0;
    bit have_prev = 1'b0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            have_prev <= 1'b0;
        end else if (in_valid && in_ready) begin
            if (have_prev) check("throughput", 32'((cyc - prev_acc) >= NDIG + 2), 32'd1);
            have_prev <= 1'b1;
            prev_acc  <= cyc;
        end
    end

    logic [W-1:0] res_sum;
    logic         res_cout, res_ovf;
    int           res_lat, res_busy;

    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                         input logic ts);
        int guard;
        guard = 0;
        in_valid = 1'b1; a = ta; b = tb; cin = tc; sub = ts;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            guard++;
            if (guard > 50) begin
                n_vec++; n_err++;
                $display("FAIL accept_timeout: in_ready stuck at 0, expected 1");
                in_valid = 1'b0;
                return;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Waits for out_valid while jabbering in_valid with garbage that must be ignored.
    task automatic wait_result();
        res_lat = 0; res_busy = 0;
        while (!out_valid && res_lat < 20) begin
            if (busy) res_busy++;
            in_valid = 1'($urandom);
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            @(posedge clk); #1;
            res_lat++;
        end
        if (!out_valid) begin
            n_vec++; n_err++;
            $display("FAIL done_timeout: out_valid 0, expected 1");
        end
        res_sum = sum; res_cout = cout; res_ovf = ovf;
    endtask

    task automatic release_result(input int hold);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check("hold_sum", 32'(sum), 32'(res_sum));
            check("hold_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                          input logic ts, input int hold);
        issue(ta, tb, tc, ts);
        wait_result();
        release_result(hold);
    endtask

    task automatic op2(input logic [1:0] ta, input logic [1:0] tb, input logic tc);
        int guard;
        guard = 0;
        in_valid_2 = 1'b1; a_2 = ta; b_2 = tb; cin_2 = tc; sub_2 = 1'b0;
        while (!in_ready_2 && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        @(posedge clk); #1;
        in_valid_2 = 1'b0;
        check("w2_busy", 32'(busy_2), 32'd1);
        @(posedge clk); #1;
        check("w2_valid", 32'(out_valid_2), 32'd1);
        check("w2_result", 32'({cout_2, sum_2}), 32'(3'(ta) + 3'(tb) + 3'(tc)));
        out_ready_2 = 1'b1;
        @(posedge clk); #1;
        out_ready_2 = 1'b0;
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] s;
        logic         co;
    } vec_t;

    initial begin
        vec_t         vecs[8];
        logic [W:0]   exp_r;
        logic [W-1:0] ra, rb;
        logic         rc;

        vecs[0] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, s: 8'h00, co: 1'b1};
        vecs[1] = '{a: 8'h5A, b: 8'h21, cin: 1'b1, s: 8'h7C, co: 1'b0};
        vecs[2] = '{a: 8'h80, b: 8'h80, cin: 1'b0, s: 8'h00, co: 1'b1};
        vecs[3] = '{a: 8'h0F, b: 8'h01, cin: 1'b0, s: 8'h10, co: 1'b0};
        vecs[4] = '{a: 8'h00, b: 8'h00, cin: 1'b0, s: 8'h00, co: 1'b0};
        vecs[5] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, s: 8'hFF, co: 1'b1};
        vecs[6] = '{a: 8'h7F, b: 8'h01, cin: 1'b0, s: 8'h80, co: 1'b0};
        vecs[7] = '{a: 8'hAA, b: 8'h55, cin: 1'b1, s: 8'h00, co: 1'b1};

        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        in_valid_2 = 1'b0; out_ready_2 = 1'b0; a_2 = '0; b_2 = '0; cin_2 = 1'b0; sub_2 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0, 0);
            check("tbl_sum", 32'(res_sum), 32'(vecs[i].s));
            check("tbl_cout", 32'(res_cout), 32'(vecs[i].co));
            check("tbl_latency", 32'(res_lat), 32'(NDIG));
            check("tbl_busy_cycles", 32'(res_busy), 32'(NDIG));
        end

        // Backpressure: result held 5 cycles, pending request ignored until IDLE.
        issue(8'h12, 8'h34, 1'b0, 1'b0);
        wait_result();
        in_valid = 1'b1; a = 8'h11; b = 8'h22; cin = 1'b1;
        for (int h = 0; h < 5; h++) begin
            @(posedge clk); #1;
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_sum", 32'(sum), 32'h46);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_busy", 32'(busy), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_idle_ready", 32'(in_ready), 32'd1);
        check("bp_idle_valid", 32'(out_valid), 32'd0);
        check("bp_retain_sum", 32'(sum), 32'h46);
        @(posedge clk); #1;
        check("bp_accept_busy", 32'(busy), 32'd1);
        in_valid = 1'b0;
        wait_result();
        check("bp_second_result", 32'({res_cout, res_sum}), 32'h034);
        release_result(0);

        // Reset in the second RUN cycle discards the operation.
        issue(8'hFF, 8'hFF, 1'b1, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_sum", 32'(sum), 32'd0);
        check("mid_rst_cout", 32'(cout), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 8; i++) begin
                @(posedge clk); #1;
                if (out_valid || busy) seen = 1'b1;
            end
            check("post_rst_quiet", 32'(seen), 32'd0);
        end
        run_op(8'h0F, 8'h01, 1'b0, 1'b0, 0);
        check("post_rst_result", 32'({res_cout, res_sum}), 32'h010);

`ifdef DSA_SUBTRACT_EN
        run_op(8'h10, 8'h01, 1'b0, 1'b1, 0);
        check("sub_sum", 32'(res_sum), 32'h0F);
        check("sub_cout", 32'(res_cout), 32'd1);
        check("sub_ovf", 32'(res_ovf), 32'd0);
        run_op(8'h80, 8'h01, 1'b1, 1'b1, 0);
        check("sub_ovf_sum", 32'(res_sum), 32'h7F);
        check("sub_ovf_flag", 32'(res_ovf), 32'd1);
        run_op(8'h7F, 8'h01, 1'b0, 1'b0, 0);
        check("add_ovf_flag", 32'(res_ovf), 32'd1);
        sub = 1'b0;
`endif

        // Random ops with idle gaps and random backpressure.
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
            ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
            exp_r = (W+1)'(ra) + (W+1)'(rb) + (W+1)'(rc);
            run_op(ra, rb, rc, 1'b0, $urandom_range(0, 3));
            check("rand_result", 32'({res_cout, res_sum}), 32'(exp_r));
        end

        // WIDTH=2 instance: single RUN cycle, then exhaustive.
        op2(2'd3, 2'd3, 1'b1);
        check("w2_sum_331", 32'(sum_2), 32'd3);
        check("w2_cout_331", 32'(cout_2), 32'd1);
        for (int i = 0; i < 32; i++) begin
            logic [4:0] v;
            v = 5'(i);
            op2(v[1:0], v[3:2], v[4]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
